// File: rtl/lna_ser_pkg.sv
// LNA serial programming: shared header with the LNA control register block.
// Holds frame width, FSM encodings and the frame bit order.
package lna_ser_pkg;

    localparam int LNA_FRAME_W = 4;
    localparam int CNT_W       = 8;

    // Bit positions inside the frame word; pd goes out first.
    localparam int PD_BIT   = 3;
    localparam int MODE_MSB = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    function automatic logic [LNA_FRAME_W-1:0] frame_word(
        input logic       pd,
        input logic [2:0] mode
    );
        logic [LNA_FRAME_W-1:0] w;
        w                  = '0;
        w[PD_BIT]          = pd;
        w[MODE_MSB:0]      = mode;
        return w;
    endfunction

endpackage

// File: rtl/lna_ser_tick.sv
// Half-period tick generator for the LNA serializer.
// Counts 0..HALF-1 while enabled and pulses tick on the last count.
module lna_ser_tick
    import lna_ser_pkg::*;
#(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick = en && !clr && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lna_ser.sv
// LNA serializer: shifts {pd, mode} MSB first on sclk, then pulses sload.
// A new frame is sent whenever the word differs from the last one sent.
module lna_ser
    import lna_ser_pkg::*;
#(
    parameter int HALF    = 2,
    parameter int FRAME_W = LNA_FRAME_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pd,
    input  logic [2:0] mode,
    output logic       sclk,
    output logic       sdata,
    output logic       sload,
    output logic       busy
);

    localparam int BIT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(FRAME_W - 1);

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [FRAME_W-1:0] s_q, s_d;
    logic               init_q, init_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               ph_q, ph_d;
    logic               sclk_q, sclk_d;
    logic               sdata_q, sdata_d;
    logic               sload_q, sload_d;
    logic               busy_q, busy_d;

    logic [FRAME_W-1:0] w;
    logic               req;
    logic               tick;
    logic               tick_clr;
    logic               tick_en;

    assign w       = FRAME_W'(frame_word(pd, mode));
    assign req     = (w != s_q) || init_q;
    assign tick_en = (state_q != ST_IDLE);

    lna_ser_tick #(
        .HALF (HALF)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .en   (tick_en),
        .tick (tick)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        s_d      = s_q;
        init_d   = init_q;
        bit_d    = bit_q;
        ph_d     = ph_q;
        sclk_d   = sclk_q;
        sdata_d  = sdata_q;
        sload_d  = sload_q;
        busy_d   = busy_q;
        tick_clr = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d  = ST_SHIFT;
                    shreg_d  = w;
                    s_d      = w;
                    init_d   = 1'b0;
                    bit_d    = BIT_TOP;
                    ph_d     = 1'b0;
                    sclk_d   = 1'b0;
                    sdata_d  = w[FRAME_W-1];
                    busy_d   = 1'b1;
                    tick_clr = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (!ph_q) begin
                        ph_d   = 1'b1;
                        sclk_d = 1'b1;
                    end else if (bit_q == '0) begin
                        // sdata keeps bit 0 through the latch phase
                        state_d = ST_LOAD;
                        ph_d    = 1'b0;
                        sclk_d  = 1'b0;
                        sload_d = 1'b1;
                    end else begin
                        bit_d   = bit_q - 1'b1;
                        ph_d    = 1'b0;
                        sclk_d  = 1'b0;
                        sdata_d = shreg_q[bit_q - 1'b1];
                    end
                end
            end
            ST_LOAD: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    sload_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sclk_d  = 1'b0;
                sload_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            s_q     <= '0;
            init_q  <= 1'b1;
            bit_q   <= '0;
            ph_q    <= 1'b0;
            sclk_q  <= 1'b0;
            sdata_q <= 1'b0;
            sload_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            s_q     <= s_d;
            init_q  <= init_d;
            bit_q   <= bit_d;
            ph_q    <= ph_d;
            sclk_q  <= sclk_d;
            sdata_q <= sdata_d;
            sload_q <= sload_d;
            busy_q  <= busy_d;
        end
    end

    assign sclk  = sclk_q;
    assign sdata = sdata_q;
    assign sload = sload_q;
    assign busy  = busy_q;

endmodule

// File: doc/lna_ser.md
LNA_SER -- requirements
Module: lna_ser

Interface
REQ-001 Parameter HALF, default 2, number of clk cycles per sclk half-period; legal range 1..255.
REQ-002 Parameter FRAME_W, default 4, frame length in bits; fixed by the frame format {pd, mode[2:0]}.
REQ-003 clk  input  1  system clock; every register updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 pd  input  1  LNA power-down level from the LNA control register block.
REQ-006 mode  input  3  LNA mode level from the LNA control register block.
REQ-007 sclk  output  1  serial clock to the analog LNA, registered.
REQ-008 sdata  output  1  serial data to the analog LNA, registered; the LNA samples it on the rising edge of sclk.
REQ-009 sload  output  1  latch strobe to the analog LNA, registered and active-high.
REQ-010 busy  output  1  high while a frame is in progress, registered.

Function
REQ-011 Frame word W = {pd, mode[2:0]}, shifted out MSB first (pd first, then mode[2], mode[1], mode[0]).
REQ-012 A shadow register S holds the last word sent; a request exists when W != S or init_pend = 1.
REQ-013 States: IDLE, SHIFT, LOAD.
- IDLE: sclk = 0, sload = 0, busy = 0.
- SHIFT: busy = 1.
- LOAD: busy = 1.
REQ-014 IDLE with a request at cycle n: the block shall capture W into the shift register and into S, clear init_pend, and enter SHIFT.
- At cycle n+1: busy = 1 and sdata = W[3].
REQ-015 SHIFT, per bit:
- sdata holds the bit for 2*HALF cycles.
- sclk = 0 for the first HALF cycles and sclk = 1 for the last HALF cycles.
- sdata changes only together with the sclk falling edge.
REQ-016 After the high phase of bit 0, the block shall enter LOAD.
- sclk = 0 and sload = 1 for HALF cycles.
- sdata holds bit 0.
- The block then returns to IDLE.
REQ-017 Frame length shall be (2*FRAME_W+1)*HALF cycles of busy = 1, i.e. 18 cycles at defaults.
REQ-018 Changes on pd/mode during SHIFT or LOAD shall not alter the frame in flight.
- The latest W is compared in IDLE on the cycle after busy falls.
- Multiple changes during a frame collapse to one follow-up frame carrying the final value.
REQ-019 A W change that reverts to S before IDLE is reached shall produce no frame.
REQ-020 An internal half-period counter shall count 0..HALF-1 and wrap; a bit counter shall count FRAME_W-1 down to 0.
- No counter shall overflow for any legal HALF.
REQ-021 In IDLE, sdata shall hold the last bit driven.

Reset
REQ-022 While rst = 1, the block shall hold:
- state = IDLE
- sclk = 0, sdata = 0, sload = 0, busy = 0
- S = 4'b0000
- init_pend = 1
- both counters = 0
REQ-023 The first cycle after rst falls shall see a request from init_pend, so one frame of the current W is sent even when W = 0.
REQ-024 rst asserted mid-frame shall abort the frame on the next edge with outputs at reset values; no sload pulse shall be emitted for the aborted frame.

Structure
REQ-025 The shared LNA header shall hold FRAME_W, the state encodings, and the frame bit order, shared with the LNA control register block.
REQ-026 One sub-module, lna_ser_tick, shall generate the half-period tick from HALF.
- It is cleared on frame start.
- The remainder of the block is a single FSM with shift and bit counters.

Verification
REQ-027 Reset release with pd = 0, mode = 0 -> one 18-cycle frame: sdata 0,0,0,0, then one sload pulse of 2 cycles, then busy = 0 and no further frames.
REQ-028 In IDLE, set pd = 1, mode = 3'b101 -> busy at the next cycle; bits sampled on sclk rising edges = 1,1,0,1; sload then pulses; S = 4'b1101.
REQ-029 During a frame carrying 4'b1101, change mode to 3'b010 then to 3'b011 -> the current frame is unchanged; exactly one follow-up frame 1,0,1,1 starts the cycle after busy falls.
REQ-030 During a frame, toggle W away and back to S -> no follow-up frame; busy stays 0 for 50 cycles.
REQ-031 Assert rst at cycle 7 of a frame -> next cycle sclk = 0, sload = 0, busy = 0; after release, an init frame of the current W is sent.
REQ-032 HALF = 1 and HALF = 5 with W = 4'b1010 -> frame lengths 9 and 45 cycles; sclk duty 50%; sdata stable across each sclk rising edge.
